// File: rtl/tap_period_avg.sv
// Tap period meter: counts tp_i pulses between button rises.
// Define TAP_PERIOD_AVG_EN to average the last 2^AVG_LOG2 periods.
module tap_period_avg #(
  parameter int CNT_WIDTH = 16,
  parameter int PER_MAX   = 62600,
  parameter int AVG_LOG2  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tp_i,
  input  logic                 btn_i,
  output logic [CNT_WIDTH-1:0] per_o,
  output logic                 per_valid_o,
  output logic                 timeout_o
);

  localparam int CW = CNT_WIDTH;
  localparam logic [CW-1:0] MAX = CW'(PER_MAX);

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            btn_old;
  logic            rise;
  logic            pub, to;
  logic            pub_q, to_q;
  logic [CW-1:0]   smp_q;

  assign rise = btn_i & ~btn_old;

  // Next state, next count and publish/timeout requests
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pub     = 1'b0;
    to      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          state_n = ARMED;
          cnt_n   = CW'(tp_i);
        end
      end
      ARMED: begin
        if (rise) begin
          pub   = (cnt != '0);
          cnt_n = CW'(tp_i);
        end else if (tp_i) begin
          if (cnt == MAX) begin
            to      = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Measurement stage: state, counter, edge history, sample capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      btn_old <= 1'b0;
      pub_q   <= 1'b0;
      to_q    <= 1'b0;
      smp_q   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      btn_old <= btn_i;
      pub_q   <= pub;
      to_q    <= to;
      if (pub) smp_q <= cnt;
    end
  end

`ifdef TAP_PERIOD_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = CW + AVG_LOG2;

  logic [CW-1:0]       hist [DEPTH];
  logic [SW-1:0]       sum, sum_n;
  logic [AVG_LOG2-1:0] ptr;
  logic                empty;

  // Running sum after admitting the captured sample
  always_comb begin
    sum_n = sum - SW'(hist[ptr]) + SW'(smp_q);
    if (empty) sum_n = SW'(smp_q) << AVG_LOG2;
  end

  // Output stage: history update and averaged period
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum         <= '0;
      ptr         <= '0;
      empty       <= 1'b1;
      per_o       <= '0;
      per_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      per_valid_o <= pub_q;
      timeout_o   <= to_q;
      if (to_q) begin
        per_o <= '0;
        empty <= 1'b1;
      end else if (pub_q) begin
        sum   <= sum_n;
        per_o <= sum_n[SW-1:AVG_LOG2];
        empty <= 1'b0;
        if (empty) begin
          for (int i = 0; i < DEPTH; i++) hist[i] <= smp_q;
        end else begin
          hist[ptr] <= smp_q;
          ptr       <= ptr + AVG_LOG2'(1);
        end
      end
    end
  end
`else
  // Output stage: raw last period
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      per_o       <= '0;
      per_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      per_valid_o <= pub_q;
      timeout_o   <= to_q;
      if (to_q)       per_o <= '0;
      else if (pub_q) per_o <= smp_q;
    end
  end
`endif

endmodule

// File: tb/tb_tap_period_avg.sv
// Directed bench for tap_period_avg (PER_MAX=100, AVG_LOG2=2).
// Expected values follow TAP_PERIOD_AVG_EN when it is defined.
module tb_tap_period_avg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tp_i;
  logic        btn_i;
  logic [15:0] per_o;
  logic        per_valid_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef TAP_PERIOD_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  tap_period_avg #(
    .CNT_WIDTH(16),
    .PER_MAX  (100),
    .AVG_LOG2 (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tp_i       (tp_i),
    .btn_i      (btn_i),
    .per_o      (per_o),
    .per_valid_o(per_valid_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk1(input logic tp, input logic btn);
    tp_i  = tp;
    btn_i = btn;
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      clk1(1'b1, 1'b0);
      clk1(1'b0, 1'b0);
    end
  endtask

  task automatic tap(input logic tp, output logic v1, output logic v2,
                     output logic [15:0] p, output logic t2,
                     output logic v3);
    clk1(tp, 1'b1);
    v1 = per_valid_o;
    clk1(1'b0, 1'b0);
    v2 = per_valid_o;
    p  = per_o;
    t2 = timeout_o;
    clk1(1'b0, 1'b0);
    v3 = per_valid_o;
  endtask

  task automatic tap_pub(input string tag, input logic tp,
                         input logic [15:0] exp);
    logic v1, v2, v3, t2;
    logic [15:0] p;
    tap(tp, v1, v2, p, t2, v3);
    chk({tag, "_early"}, v1, 0);
    chk({tag, "_vld"}, v2, 1);
    chk({tag, "_per"}, p, exp);
    chk({tag, "_to"}, t2, 0);
    chk({tag, "_1cyc"}, v3, 0);
  endtask

  task automatic tap_none(input string tag, input logic tp,
                          input logic [15:0] exp);
    logic v1, v2, v3, t2;
    logic [15:0] p;
    tap(tp, v1, v2, p, t2, v3);
    chk({tag, "_v1"}, v1, 0);
    chk({tag, "_v2"}, v2, 0);
    chk({tag, "_v3"}, v3, 0);
    chk({tag, "_per"}, p, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    tp_i  = 1'b0;
    btn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_per", per_o, 0);
    chk("rst_vld", per_valid_o, 0);
    chk("rst_to", timeout_o, 0);
    rst_i = 1'b0;
    clk1(1'b0, 1'b0);

    // first period
    tap_none("first", 1'b0, 0);
    pulses(10);
    tap_pub("p10", 1'b0, 10);

    // averaging 10 then 20s
    pulses(20);
    tap_pub("p20a", 1'b0, AVG ? 16'd12 : 16'd20);
    pulses(20);
    tap_pub("p20b", 1'b0, AVG ? 16'd15 : 16'd20);
    pulses(20);
    tap_pub("p20c", 1'b0, AVG ? 16'd17 : 16'd20);
    pulses(20);
    tap_pub("p20d", 1'b0, 20);
    pulses(20);
    tap_pub("p20e", 1'b0, 20);

    // rise coincident with tp at count 7
    pulses(7);
    tap_pub("coin7", 1'b1, AVG ? 16'd16 : 16'd7);
    pulses(9);
    tap_pub("coin10", 1'b0, AVG ? 16'd14 : 16'd10);

    // zero period: discarded, history untouched
    tap_none("zero", 1'b0, AVG ? 16'd14 : 16'd10);
    pulses(5);
    tap_pub("after0", 1'b0, AVG ? 16'd10 : 16'd5);

    // timeout on the 101st pulse
    pulses(100);
    chk("to_pre", timeout_o, 0);
    clk1(1'b1, 1'b0);
    chk("to_early", timeout_o, 0);
    clk1(1'b0, 1'b0);
    chk("to_strb", timeout_o, 1);
    chk("to_per", per_o, 0);
    chk("to_novld", per_valid_o, 0);
    clk1(1'b0, 1'b0);
    chk("to_1cyc", timeout_o, 0);
    tap_none("to_rearm", 1'b0, 0);
    pulses(10);
    tap_pub("to_raw", 1'b0, 10);

    // async reset while the strobe is high
    pulses(4);
    clk1(1'b0, 1'b1);
    clk1(1'b0, 1'b0);
    chk("pre_rst_vld", per_valid_o, 1);
    chk("pre_rst_per", per_o, AVG ? 16'd8 : 16'd4);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_per", per_o, 0);
    chk("arst_vld", per_valid_o, 0);
    chk("arst_to", timeout_o, 0);
    rst_i = 1'b0;
    pulses(5);
    tap_none("rst_tap", 1'b0, 0);
    pulses(6);
    tap_pub("rst_p6", 1'b0, 6);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tap_period_avg.md
# tap_period_avg

Measures the interval between rising edges of the debounced tap button in time-base pulses (`tp_i`) and reports it on a registered output with a one-cycle valid strobe. It generalises the basic tap period counter:
- parametrised counter width and saturation limit;
- explicit idle/armed state, so the first tap after idle only starts timing;
- timeout when no tap arrives within `PER_MAX` pulses;
- optional running average over the last 2^`AVG_LOG2` periods.

It sits between the button debouncer and the BPM conversion logic.

## Interface
- `CNT_WIDTH`, default 16: period counter and output width; must satisfy 2^`CNT_WIDTH` > `PER_MAX`.
- `PER_MAX`, default 62600: longest valid period in `tp_i` pulses; reaching it triggers a timeout.
- `AVG_LOG2`, default 2: log2 of averaging depth (depth 4); used only when `TAP_PERIOD_AVG_EN` is defined.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset: asynchronous, active-high.
- `tp_i`  in  1  time-base pulse, one `clk_i` cycle wide, synchronous to `clk_i`.
- `btn_i`  in  1  debounced button level, synchronous to `clk_i`.
- `per_o`  out  `CNT_WIDTH`  last measured (or averaged) period in `tp_i` units.
- `per_valid_o`  out  1  one-cycle strobe: `per_o` updated.
- `timeout_o`  out  1  one-cycle strobe: `PER_MAX` exceeded, block returned to IDLE.

## Operation
- Edge detect: register `btn_old` (reset 0); `rise = btn_i & ~btn_old`.
- **IDLE** (reset state):
  - counter held at 0.
  - On `rise`: go to ARMED; counter ← `tp_i` (0 or 1); no strobe.
- **ARMED**, priority order:
  - **rise**: sample = counter.
    - If sample == 0, the sample is discarded: no strobe, stay ARMED.
    - Otherwise the sample is published (see averaging).
    - Counter ← `tp_i` in both cases; a `tp_i` coincident with `rise` is credited to the new period.
  - **`tp_i` with counter == `PER_MAX`**:
    - go to IDLE; counter ← 0; `per_o` ← 0; `timeout_o` = 1 for one cycle;
    - averaging history marked empty.
  - **`tp_i` otherwise**: counter ← counter + 1.
  - Counter never exceeds `PER_MAX`; there is no wrap-around.
- Publish without averaging: `per_o` ← sample.
- Publish with averaging:
  - History is 2^`AVG_LOG2` entries plus a running sum of width `CNT_WIDTH`+`AVG_LOG2`.
  - First publish after IDLE or reset (history empty): all entries ← sample; sum ← sample << `AVG_LOG2`.
  - Otherwise: sum ← sum − oldest + sample; the oldest entry is replaced.
  - `per_o` ← new sum >> `AVG_LOG2` (truncating).
- Reset at any time: IDLE, counter 0, history empty, all outputs 0.

## Timing
- Reset values: `per_o` = 0, `per_valid_o` = 0, `timeout_o` = 0.
- Latency: `btn_i` first sampled high on edge N → `per_o` updated and `per_valid_o` = 1 after edge N+1, for exactly one cycle.
- Timeout: `tp_i` sampled at edge M with counter == `PER_MAX` → `timeout_o` = 1 after edge M+1, for one cycle.
- `per_valid_o` and `timeout_o` are never asserted in the same cycle.
- `per_o` is stable between strobes.
- No back-pressure: the consumer must accept each strobe.
- Back-to-back taps every 2 cycles are legal; each tap with a nonzero count publishes.

## Configuration
- Macro: `TAP_PERIOD_AVG_EN`.
  - **Defined**: history RAM/registers, running sum and averaged output as described; `AVG_LOG2` is used.
  - **Undefined**: no history logic; `per_o` is the raw last sample; `AVG_LOG2` is ignored.
- Latency and strobe timing are identical in both builds.

## Test plan
All scenarios use `PER_MAX` = 100 and `AVG_LOG2` = 2.
- **Reset**: assert `rst_i` mid-simulation → `per_o` = 0, `per_valid_o` = 0, `timeout_o` = 0 asynchronously; next tap publishes nothing.
- **First period**: taps spaced by 10 `tp_i` pulses → first tap gives no strobe; second tap gives `per_o` = 10 with a single-cycle `per_valid_o` one cycle after the rise. Same value in both builds.
- **Averaging**: periods 10 then 20:
  - with `TAP_PERIOD_AVG_EN`, `per_o` = 12 (sum 50 >> 2); four more 20-periods reach 20;
  - without the macro, `per_o` = 20.
- **Timeout**: after a tap, 101 `tp_i` pulses with no tap → `timeout_o` strobe on the 101st pulse and `per_o` = 0. The next tap gives no strobe; the following tap publishes the raw period in both builds (averaging restarts).
- **Coincidence**: `rise` in the same cycle as `tp_i` with counter = 7 → `per_o` = 7. Nine further pulses before the next tap → raw period 10.
- **Zero period**: two rises with no `tp_i` between them → no strobe, no change to `per_o` or history.
